// File: rtl/ls_exec_unit.sv
// ls_exec_unit: load/store execution unit. It computes effective addresses, runs loads through
// the memory-controller port, and returns store address/data to the ROB for the write at commit.
module ls_exec_unit #(
   parameter logic [31:0] IO_BASE  = 32'h00030000,
   parameter int          ROB_ID_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rdy,
   input  logic                LSB_input_valid,
   input  logic [5:0]          LSB_OP_ID,
   input  logic [31:0]         LSB_inst_pc,
   input  logic [31:0]         LSB_reg_rs1,
   input  logic [31:0]         LSB_reg_rs2,
   input  logic [31:0]         LSB_imm,
   input  logic [ROB_ID_W-1:0] LSB_ROB_id,
   output logic                ALU_ready,
   output logic                MC_req_valid,
   output logic [31:0]         MC_addr,
   output logic [1:0]          MC_size,
   input  logic                MC_done,
   input  logic [31:0]         MC_data,
   input  logic [ROB_ID_W-1:0] ROB_head_ROB_id,
   input  logic                ROB_roll_back_flag,
   output logic                ROB_output_valid,
   output logic [ROB_ID_W-1:0] ROB_ROB_id,
   output logic [31:0]         ROB_value,
   output logic                ROB_is_store,
   output logic [31:0]         ROB_store_addr,
   output logic [31:0]         ROB_store_data,
   output logic [1:0]          ROB_store_size
);
   localparam logic [5:0] OP_LB = 6'd1, OP_LH = 6'd2, OP_LW = 6'd3, OP_LBU = 6'd4, OP_LHU = 6'd5;
   localparam logic [5:0] OP_SB = 6'd6, OP_SH = 6'd7, OP_SW = 6'd8;

   typedef enum logic [1:0] {S_IDLE, S_IO_WAIT, S_MEM_WAIT, S_DRAIN} state_t;

   state_t                r_state, w_next;
   logic [ROB_ID_W-1:0]   r_tag;
   logic [31:0]           r_addr;
   logic [1:0]            r_size;
   logic                  r_signed;
   logic                  r_out_valid, r_is_store;
   logic [ROB_ID_W-1:0]   r_rob_id;
   logic [31:0]           r_value, r_store_addr, r_store_data;
   logic [1:0]            r_store_size;

   logic [31:0] w_addr, w_sdata, w_ext;
   logic [1:0]  w_size;
   logic        w_is_load, w_is_store, w_signed;
   logic        w_accept, w_store_fire, w_load_accept, w_load_done;
   logic        w_unused_pc;

   assign w_unused_pc  = ^LSB_inst_pc;
   assign w_addr       = LSB_reg_rs1 + LSB_imm;
   assign w_is_load    = LSB_OP_ID == OP_LB || LSB_OP_ID == OP_LH || LSB_OP_ID == OP_LW ||
                         LSB_OP_ID == OP_LBU || LSB_OP_ID == OP_LHU;
   assign w_is_store   = LSB_OP_ID == OP_SB || LSB_OP_ID == OP_SH || LSB_OP_ID == OP_SW;
   assign w_signed     = LSB_OP_ID == OP_LB || LSB_OP_ID == OP_LH;
   assign w_size       = (LSB_OP_ID == OP_LB || LSB_OP_ID == OP_LBU || LSB_OP_ID == OP_SB) ? 2'd0 :
                         (LSB_OP_ID == OP_LH || LSB_OP_ID == OP_LHU || LSB_OP_ID == OP_SH) ? 2'd1 : 2'd2;
   assign w_sdata      = (w_size == 2'd0) ? {24'h0, LSB_reg_rs2[7:0]} :
                         (w_size == 2'd1) ? {16'h0, LSB_reg_rs2[15:0]} : LSB_reg_rs2;
   assign w_ext        = (r_size == 2'd0) ? {{24{r_signed & MC_data[7]}}, MC_data[7:0]} :
                         (r_size == 2'd1) ? {{16{r_signed & MC_data[15]}}, MC_data[15:0]} : MC_data;

   // Roll back outranks everything: a same-cycle issue or completion produces no result.
   assign w_accept      = r_state == S_IDLE && LSB_input_valid && !ROB_roll_back_flag;
   assign w_store_fire  = w_accept && w_is_store;
   assign w_load_accept = w_accept && w_is_load;
   assign w_load_done   = r_state == S_MEM_WAIT && MC_done && !ROB_roll_back_flag;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:     w_next = w_load_accept ? ((w_addr >= IO_BASE) ? S_IO_WAIT : S_MEM_WAIT) : S_IDLE;
         S_IO_WAIT:  w_next = ROB_roll_back_flag ? S_IDLE :
                              (ROB_head_ROB_id == r_tag) ? S_MEM_WAIT : S_IO_WAIT;
         S_MEM_WAIT: w_next = MC_done ? S_IDLE : ROB_roll_back_flag ? S_DRAIN : S_MEM_WAIT;
         S_DRAIN:    w_next = MC_done ? S_IDLE : S_DRAIN;
         default:    w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) r_state <= S_IDLE;
      else if (rdy) r_state <= w_next;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tag        <= '0;
         r_addr       <= '0;
         r_size       <= '0;
         r_signed     <= 1'b0;
         r_out_valid  <= 1'b0;
         r_is_store   <= 1'b0;
         r_rob_id     <= '0;
         r_value      <= '0;
         r_store_addr <= '0;
         r_store_data <= '0;
         r_store_size <= '0;
      end else if (rdy) begin
         r_out_valid <= w_store_fire || w_load_done;
         if (w_load_accept) begin
            r_tag    <= LSB_ROB_id;
            r_addr   <= w_addr;
            r_size   <= w_size;
            r_signed <= w_signed;
         end
         if (w_store_fire) begin
            r_rob_id     <= LSB_ROB_id;
            r_is_store   <= 1'b1;
            r_store_addr <= w_addr;
            r_store_data <= w_sdata;
            r_store_size <= w_size;
         end
         if (w_load_done) begin
            r_rob_id   <= r_tag;
            r_is_store <= 1'b0;
            r_value    <= w_ext;
         end
      end
   end

   // Request is a function of state alone so an async reset drops it immediately.
   assign ALU_ready        = r_state == S_IDLE;
   assign MC_req_valid     = r_state == S_MEM_WAIT || r_state == S_DRAIN;
   assign MC_addr          = r_addr;
   assign MC_size          = r_size;
   assign ROB_output_valid = r_out_valid;
   assign ROB_ROB_id       = r_rob_id;
   assign ROB_value        = r_value;
   assign ROB_is_store     = r_is_store;
   assign ROB_store_addr   = r_store_addr;
   assign ROB_store_data   = r_store_data;
   assign ROB_store_size   = r_store_size;
endmodule
